// File: rtl/led_pkg.sv
// Shared types and round-robin helper for the LED blink arbiter.
package led_pkg;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IW       = 3;
  localparam int unsigned SW       = IW + 1;

  typedef enum logic [1:0] {IDLE, ON, OFF} blink_state_t;

  // First set request at or above ptr, wrapping modulo n (n <= MAX_NREQ, ptr < n).
  function automatic logic [IW-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                            input logic [IW-1:0]       ptr,
                                            input int unsigned         n);
    logic [SW-1:0] s;
    logic [IW-1:0] win;
    logic          found;
    win   = ptr;
    found = 1'b0;
    s     = '0;
    for (int i = 0; i < int'(MAX_NREQ); i++) begin
      s = {1'b0, ptr} + SW'(i);
      if (s >= SW'(n)) s = s - SW'(n);
      if (!found && (i < int'(n)) && req[s[IW-1:0]]) begin
        win   = s[IW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/led_blink_arbiter_if.sv
// Requester-side bus of the LED blink arbiter: requests, blink parameters, status.
interface led_blink_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 16,
  parameter int unsigned RW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] on_ticks;
  logic [NREQ*DW-1:0] off_ticks;
  logic [NREQ*RW-1:0] reps;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               done;
  logic               led0_b;

  modport master (output req, on_ticks, off_ticks, reps,
                  input  grant, busy, done, led0_b);
  modport slave  (input  req, on_ticks, off_ticks, reps,
                  output grant, busy, done, led0_b);
endinterface

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every DIV clocks; clr restarts the count so the next tick is DIV cycles away.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  // tick is registered high exactly while cnt_q sits at DIV-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
      tick  <= (cnt_q == CW'(DIV - 2));
    end
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin owner of a single board LED; plays the granted requester's on/off/repeat pattern.
module led_blink_arbiter
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1_000,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned RW      = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  led_blink_arbiter_if.slave  bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;

  blink_state_t      state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              led_q, led_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [DW-1:0]     phase_q, phase_d;
  logic [DW-1:0]     on_q, on_d;
  logic [DW-1:0]     off_q, off_d;
  logic [RW-1:0]     reps_q, reps_d;
  logic [RW-1:0]     cyc_q, cyc_d;

  logic              tick;
  logic              tick_clr;
  logic              seq_end;
  logic              phase_last;
  logic [IW-1:0]     pick;
  logic [MAX_NREQ-1:0] req_pad;
  logic [DW-1:0]     on_sel, off_sel;
  logic [RW-1:0]     reps_sel;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tick_clr),
    .tick    (tick)
  );

  assign req_pad    = MAX_NREQ'(bus.req);
  assign pick       = rr_pick(req_pad, ptr_q, NREQ);
  assign on_sel     = bus.on_ticks [32'(pick) * DW +: DW];
  assign off_sel    = bus.off_ticks[32'(pick) * DW +: DW];
  assign reps_sel   = bus.reps     [32'(pick) * RW +: RW];
  assign phase_last = (phase_q == (((state_q == ON) ? on_q : off_q) - DW'(1)));

  assign bus.grant  = grant_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.led0_b = led_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    led_d    = led_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    phase_d  = phase_q;
    cyc_d    = cyc_q;
    on_d     = on_q;
    off_d    = off_q;
    reps_d   = reps_q;
    tick_clr = 1'b0;
    seq_end  = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        led_d   = 1'b0;
        if (|bus.req) begin
          state_d  = ON;
          win_d    = pick;
          grant_d  = NREQ'(1) << pick;
          busy_d   = 1'b1;
          led_d    = 1'b1;
          on_d     = (on_sel  == '0) ? DW'(1) : on_sel;
          off_d    = (off_sel == '0) ? DW'(1) : off_sel;
          reps_d   = reps_sel;
          phase_d  = '0;
          cyc_d    = '0;
          tick_clr = 1'b1;
        end
      end
      ON: begin
        if (tick) begin
          if (phase_last) begin
            phase_d = '0;
            state_d = OFF;
            led_d   = 1'b0;
          end else begin
            phase_d = phase_q + DW'(1);
          end
        end
      end
      OFF: begin
        if (tick) begin
          if (phase_last) begin
            phase_d = '0;
            cyc_d   = cyc_q + RW'(1);
            // Fixed count ignores req; continuous mode stops once the owner lets go
            seq_end = (reps_q != '0) ? (cyc_d == reps_q) : !req_pad[win_q];
            if (seq_end) begin
              state_d = IDLE;
              grant_d = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              ptr_d   = ((32'(win_q) + 32'd1) >= NREQ) ? '0 : win_q + IW'(1);
            end else begin
              state_d = ON;
              led_d   = 1'b1;
            end
          end else begin
            phase_d = phase_q + DW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        led_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
      phase_q <= '0;
      cyc_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
      reps_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      phase_q <= phase_d;
      cyc_q   <= cyc_d;
      on_q    <= on_d;
      off_q   <= off_d;
      reps_q  <= reps_d;
    end
  end

endmodule
